// File: rtl/rle_pkg.sv
// Shared definitions for the RLE compressor/decompressor pair: FSM states,
// word geometry and the 16-bit (symbol, count) entry layout.
package rle_pkg;

   localparam int WORD_BYTES = 4;
   localparam int ENTRY_W    = 16;
   localparam int CNT_LSB    = 0;
   localparam int SYM_LSB    = 8;
   localparam int FIELD_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DECODE = 3'd3,
      ST_WRITE  = 3'd4,
      ST_FINISH = 3'd5,
      ST_FLUSH  = 3'd6
   } rle_state_t;

   function automatic logic [FIELD_W-1:0] entry_sym(input logic [ENTRY_W-1:0] e);
      return e[SYM_LSB +: FIELD_W];
   endfunction

   function automatic logic [FIELD_W-1:0] entry_cnt(input logic [ENTRY_W-1:0] e);
      return e[CNT_LSB +: FIELD_W];
   endfunction

endpackage

// File: rtl/rle_byte_packer.sv
// Four-byte little-endian accumulator. Unfilled upper lanes read as zero,
// so a partially filled word can be written out directly as padded data.
module rle_byte_packer
   import rle_pkg::*;
(
   input  logic        clk,
   input  logic        nreset,
   input  logic        push,
   input  logic        push4,
   input  logic        clear,
   input  logic [7:0]  sym,
   output logic        full,
   output logic        empty,
   output logic [2:0]  level,
   output logic [31:0] word
);

   logic [31:0] r_word;
   logic [2:0]  r_level;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_word  <= '0;
         r_level <= '0;
      end else if (clear) begin
         r_word  <= '0;
         r_level <= '0;
      end else if (push4) begin
         r_word  <= {WORD_BYTES{sym}};
         r_level <= 3'(WORD_BYTES);
      end else if (push) begin
         r_word[{r_level[1:0], 3'b000} +: 8] <= sym;
         r_level                             <= r_level + 3'd1;
      end
   end

   assign full  = (r_level == 3'(WORD_BYTES));
   assign empty = (r_level == 3'd0);
   assign level = r_level;
   assign word  = r_word;

endmodule

// File: rtl/rle_decode.sv
// Run-length decompressor: reads (symbol, count) entry words from SRAM port A
// and writes expanded bytes back packed four per word. Optional one-cycle word
// fill for long runs is enabled by defining RLE_DEC_WORD_FILL_EN.
module rle_decode
   import rle_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic [31:0]       rle_addr,
   input  logic [31:0]       rle_size,
   input  logic [31:0]       out_addr,
   output logic [31:0]       out_size,
   output logic              done,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   output logic              port_A_we,
   output logic [31:0]       port_A_data_in,
   input  logic [31:0]       port_A_data_out,
   output logic [2:0]        dbg_state
);

   // Job protocol: start is a one-cycle request honoured only in IDLE; done is
   // a level that holds in IDLE from job completion until the next accepted start.

   rle_state_t        r_state;
   rle_state_t        w_next;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [31:0]       r_size;
   logic [31:0]       r_consumed;
   logic [15:0]       r_hi_entry;
   logic              r_sel;
   logic [7:0]        r_sym;
   logic [7:0]        r_remain;
   logic [31:0]       r_out_size;
   logic              r_done;

   logic              w_push;
   logic              w_push4;
   logic              w_clear;
   logic              w_load1;
   logic              w_full;
   logic              w_empty;
   logic [2:0]        w_level;
   logic [31:0]       w_word;
   logic              w_fill_en;
   logic              w_unused;

`ifdef RLE_DEC_WORD_FILL_EN
   assign w_fill_en = 1'b1;
`else
   assign w_fill_en = 1'b0;
`endif

   rle_byte_packer u_packer (
      .clk    (clk),
      .nreset (nreset),
      .push   (w_push),
      .push4  (w_push4),
      .clear  (w_clear),
      .sym    (r_sym),
      .full   (w_full),
      .empty  (w_empty),
      .level  (w_level),
      .word   (w_word)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_push  = 1'b0;
      w_push4 = 1'b0;
      w_clear = 1'b0;
      w_load1 = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_clear = 1'b1;
               w_next  = (rle_size[31:2] != 30'd0) ? ST_FETCH : ST_FLUSH;
            end
         end
         ST_FETCH: w_next = ST_WAIT;
         ST_WAIT:  w_next = ST_DECODE;
         ST_DECODE: begin
            if (r_remain == 8'd0) begin
               if (!r_sel)                     w_load1 = 1'b1;
               else if (r_consumed == r_size) w_next  = ST_FINISH;
               else                            w_next  = ST_FETCH;
            end else if (w_fill_en && w_empty && r_remain >= 8'd4) begin
               w_push4 = 1'b1;
               w_next  = ST_WRITE;
            end else begin
               w_push = 1'b1;
               // The byte pushed now completes the word.
               if (w_level == 3'd3) w_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_clear = 1'b1;
            w_next  = ST_DECODE;
         end
         ST_FINISH: w_next = ST_FLUSH;
         ST_FLUSH:  w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_rd_addr  <= '0;
         r_wr_addr  <= '0;
         r_size     <= '0;
         r_consumed <= '0;
         r_hi_entry <= '0;
         r_sel      <= 1'b0;
         r_sym      <= '0;
         r_remain   <= '0;
         r_out_size <= '0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_rd_addr  <= rle_addr[ADDR_W-1:0];
                  r_wr_addr  <= out_addr[ADDR_W-1:0];
                  r_size     <= {rle_size[31:2], 2'b00};
                  r_consumed <= '0;
                  r_out_size <= '0;
                  r_done     <= 1'b0;
                  r_sel      <= 1'b0;
                  r_remain   <= '0;
               end
            end
            ST_WAIT: begin
               r_hi_entry <= port_A_data_out[31:16];
               r_sym      <= entry_sym(port_A_data_out[15:0]);
               r_remain   <= entry_cnt(port_A_data_out[15:0]);
               r_sel      <= 1'b0;
               r_rd_addr  <= r_rd_addr + ADDR_W'(WORD_BYTES);
               r_consumed <= r_consumed + 32'(WORD_BYTES);
            end
            ST_DECODE: begin
               if (w_load1) begin
                  r_sel    <= 1'b1;
                  r_sym    <= entry_sym(r_hi_entry);
                  r_remain <= entry_cnt(r_hi_entry);
               end else if (w_push4) begin
                  r_remain   <= r_remain - 8'd4;
                  r_out_size <= r_out_size + 32'd4;
               end else if (w_push) begin
                  r_remain   <= r_remain - 8'd1;
                  r_out_size <= r_out_size + 32'd1;
               end
            end
            ST_WRITE: r_wr_addr <= r_wr_addr + ADDR_W'(WORD_BYTES);
            ST_FLUSH: begin
               r_done <= 1'b1;
               if (!w_empty) r_wr_addr <= r_wr_addr + ADDR_W'(WORD_BYTES);
            end
            default: ;
         endcase
      end
   end

   // Port A is driven combinationally from state so FETCH and WRITE each own
   // the port for exactly their cycle; every other state leaves it at zero.
   always_comb begin
      port_A_we      = (r_state == ST_WRITE) || ((r_state == ST_FLUSH) && !w_empty);
      port_A_addr    = '0;
      port_A_data_in = '0;
      if (r_state == ST_FETCH) begin
         port_A_addr = r_rd_addr;
      end else if (port_A_we) begin
         port_A_addr    = r_wr_addr;
         port_A_data_in = w_word;
      end
   end

   assign port_A_clk = clk;
   assign out_size   = r_out_size;
   assign done       = r_done;
   assign dbg_state  = r_state;
   assign w_unused   = ^{rle_addr, out_addr, rle_size[1:0], w_full};

endmodule

// File: tb/tb_rle_decode.sv
// Directed bench for rle_decode: table of stream vectors with hand-computed
// results, a reset-during-decode sequence and random round-trip messages.
module tb_rle_decode;

   localparam logic [31:0] RLE_BASE = 32'h0000_0100;
   localparam logic [31:0] OUT_BASE = 32'h0000_1000;
   localparam int          TIMEOUT  = 2000;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] rle_addr = '0;
   logic [31:0] rle_size = '0;
   logic [31:0] out_addr = '0;
   logic [31:0] out_size;
   logic        done;
   logic        port_A_clk;
   logic [15:0] port_A_addr;
   logic        port_A_we;
   logic [31:0] port_A_data_in;
   logic [31:0] port_A_data_out = '0;
   logic [2:0]  dbg_state;

   rle_decode #(.ADDR_W(16)) dut (
      .clk             (clk),
      .nreset          (nreset),
      .start           (start),
      .rle_addr        (rle_addr),
      .rle_size        (rle_size),
      .out_addr        (out_addr),
      .out_size        (out_size),
      .done            (done),
      .port_A_clk      (port_A_clk),
      .port_A_addr     (port_A_addr),
      .port_A_we       (port_A_we),
      .port_A_data_in  (port_A_data_in),
      .port_A_data_out (port_A_data_out),
      .dbg_state       (dbg_state)
   );

   always #5 clk = ~clk;

   // SRAM model: source region is preloaded by the bench, destination region
   // is written only by the DUT.
   logic [31:0] src_mem [256];
   logic [31:0] dst_mem [256];
   logic [15:0] lat_addr = '0;
   logic        lat_we = 1'b0;
   logic [31:0] lat_data = '0;

   int          errors = 0;
   int          checks = 0;
   int          wr_cnt = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_addr_q[$];

   always @(negedge clk) begin
      lat_addr = port_A_addr;
      lat_we   = port_A_we;
      lat_data = port_A_data_in;
   end

   always @(posedge clk) begin
      if (lat_we) dst_mem[lat_addr[9:2]] <= lat_data;
      else        port_A_data_out <= src_mem[lat_addr[9:2]];
   end

   // Write scoreboard.
   always @(negedge clk) begin
      if (nreset && port_A_we) begin
         wr_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_extra: addr %h data %h, no write expected", port_A_addr, port_A_data_in);
         end else begin
            logic [31:0] e;
            logic [15:0] a;
            e = exp_q.pop_front();
            a = exp_addr_q.pop_front();
            if (port_A_data_in !== e || port_A_addr !== a) begin
               errors++;
               $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                        port_A_addr, port_A_data_in, a, e);
            end
         end
      end
   end

   typedef struct {
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] size;
      logic [31:0] exp_size;
      int          exp_writes;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
      int          exp_cyc;
      int          exp_cyc_fill;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pack_expect(input logic [7:0] bq[$]);
      int n;
      logic [31:0] w;
      n = bq.size();
      for (int k = 0; k < (n + 3) / 4; k++) begin
         w = '0;
         for (int b = 0; b < 4; b++)
            if (4 * k + b < n) w[8*b +: 8] = bq[4*k + b];
         exp_q.push_back(w);
         exp_addr_q.push_back(16'(OUT_BASE + 32'(4 * k)));
      end
   endtask

   task automatic build_expect(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] sz);
      logic [7:0]  bq[$];
      logic [31:0] wd;
      logic [7:0]  sym;
      logic [7:0]  cnt;
      for (int i = 0; i < 2; i++) begin
         if (32'(i) < (sz >> 2)) begin
            wd = (i == 0) ? w0 : w1;
            for (int e = 0; e < 2; e++) begin
               sym = wd[16*e + 8 +: 8];
               cnt = wd[16*e +: 8];
               for (int c = 0; c < int'(cnt); c++) bq.push_back(sym);
            end
         end
      end
      pack_expect(bq);
   endtask

   task automatic run_job(input logic [31:0] sz, output int cyc);
      logic seen;
      @(negedge clk);
      rle_addr = RLE_BASE;
      out_addr = OUT_BASE;
      rle_size = sz;
      start    = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < TIMEOUT) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (done) seen = 1'b1;
      end
      check("done_within_budget", 32'(seen), 32'd1);
   endtask

   task automatic run_vec(input int i);
      int cyc;
      src_mem[RLE_BASE >> 2]       = vecs[i].w0;
      src_mem[(RLE_BASE >> 2) + 1] = vecs[i].w1;
      wr_cnt = 0;
      build_expect(vecs[i].w0, vecs[i].w1, vecs[i].size);
      run_job(vecs[i].size, cyc);
      check($sformatf("v%0d out_size", i), out_size, vecs[i].exp_size);
      check($sformatf("v%0d done", i), 32'(done), 32'd1);
      check($sformatf("v%0d writes", i), 32'(wr_cnt), 32'(vecs[i].exp_writes));
`ifdef RLE_DEC_WORD_FILL_EN
      check($sformatf("v%0d cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc_fill));
`else
      check($sformatf("v%0d cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
`endif
      if (vecs[i].exp_writes > 0) begin
         check($sformatf("v%0d first_word", i), dst_mem[0], vecs[i].exp_first);
         check($sformatf("v%0d last_word", i), dst_mem[vecs[i].exp_writes - 1], vecs[i].exp_last);
      end
      check($sformatf("v%0d writes_pending", i), 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0]  msg[$];
      logic [15:0] ent[$];
      logic [7:0]  sym;
      int          len;
      int          cyc;
      int          mism;
      int          nw;

      //              w0            w1            size   out    wr  first         last          cyc  fill
      vecs[0] = '{32'h4203_4105, 32'h0000_0000, 32'd4, 32'd8,   2, 32'h4141_4141, 32'h4242_4241, 17,  14};
      vecs[1] = '{32'h0000_7A02, 32'h0000_0000, 32'd4, 32'd2,   1, 32'h0000_7A7A, 32'h0000_7A7A, 9,   9};
      vecs[2] = '{32'h1234_5678, 32'h0000_0000, 32'd0, 32'd0,   0, 32'h0,         32'h0,         2,   2};
      vecs[3] = '{32'h0000_FFFF, 32'h0000_0000, 32'd4, 32'd255, 64, 32'hFFFF_FFFF, 32'h00FF_FFFF, 325, 136};
      vecs[4] = '{32'h4301_4302, 32'h4400_4405, 32'd8, 32'd8,   2, 32'h4443_4343, 32'h4444_4444, 21,  18};
      vecs[5] = '{32'h0000_4101, 32'h4205_4205, 32'd7, 32'd1,   1, 32'h0000_0041, 32'h0000_0041, 8,   8};
      vecs[6] = '{32'h0000_0000, 32'h0000_0000, 32'd4, 32'd0,   0, 32'h0,         32'h0,         7,   7};
      vecs[7] = '{32'h0000_4104, 32'h0000_0000, 32'd4, 32'd4,   1, 32'h4141_4141, 32'h4141_4141, 12,  9};

      repeat (3) @(negedge clk);
      check("reset out_size", out_size, 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset we", 32'(port_A_we), 32'd0);
      check("reset addr", 32'(port_A_addr), 32'd0);
      check("reset data_in", port_A_data_in, 32'd0);
      check("reset state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      nreset = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(i);

      // Reset in the middle of a long run, then a clean job from scratch.
      src_mem[RLE_BASE >> 2] = 32'h0000_FFFF;
      build_expect(32'h0000_FFFF, 32'h0, 32'd4);
      @(negedge clk);
      rle_addr = RLE_BASE;
      out_addr = OUT_BASE;
      rle_size = 32'd4;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      check("mid_job in decode", 32'(dbg_state), 32'd3);
      nreset = 1'b0;
      #1;
      check("mid_reset we", 32'(port_A_we), 32'd0);
      check("mid_reset done", 32'(done), 32'd0);
      check("mid_reset out_size", out_size, 32'd0);
      check("mid_reset state", 32'(dbg_state), 32'd0);
      exp_q.delete();
      exp_addr_q.delete();
      @(negedge clk);
      nreset = 1'b1;
      run_vec(0);

      // Round trip of random 64-byte messages through a bench-side encoder.
      for (int m = 0; m < 3; m++) begin
         msg.delete();
         ent.delete();
         while (msg.size() < 64) begin
            sym = 8'h30 + 8'($urandom_range(0, 3));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len && msg.size() < 64; k++) msg.push_back(sym);
         end
         for (int k = 0; k < 64; ) begin
            len = 1;
            while (k + len < 64 && msg[k + len] == msg[k]) len++;
            ent.push_back({msg[k], 8'(len)});
            k += len;
         end
         if (ent.size() % 2 != 0) ent.push_back(16'h0000);
         nw = ent.size() / 2;
         for (int k = 0; k < nw; k++)
            src_mem[(RLE_BASE >> 2) + k] = {ent[2*k + 1], ent[2*k]};
         wr_cnt = 0;
         pack_expect(msg);
         run_job(32'(4 * nw), cyc);
         check($sformatf("rt%0d out_size", m), out_size, 32'd64);
         check($sformatf("rt%0d writes", m), 32'(wr_cnt), 32'd16);
         mism = 0;
         for (int k = 0; k < 16; k++)
            if (dst_mem[k] !== {msg[4*k + 3], msg[4*k + 2], msg[4*k + 1], msg[4*k]}) mism++;
         check($sformatf("rt%0d dst_words_wrong", m), 32'(mism), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rle_decode.md
# rle_decode

Run-length decompressor that sits directly downstream of the RLE compressor. It reads a packed stream of (symbol, count) entries from the shared dual-port SRAM through port A and expands each run into plaintext bytes. The bytes are packed four per word and written back to a second region of the same SRAM. The expanded length is reported on `out_size`, and completion is signalled on `done`.

## Interface
Parameters:
- `ADDR_W`, 16. Width of the SRAM address; the low `ADDR_W` bits of the address inputs are used.

Ports:
- `clk`  in  1  system clock
- `nreset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; sampled only in IDLE
- `rle_addr`  in  32  byte address of the compressed stream (word aligned)
- `rle_size`  in  32  compressed length in bytes; bits [1:0] are ignored (rounded down to a whole word)
- `out_addr`  in  32  byte address of the plaintext destination (word aligned)
- `out_size`  out  32  number of plaintext bytes produced
- `done`  out  1  high in IDLE after a completed job, until the next accepted `start`
- `port_A_clk`  out  1  driven by `clk`
- `port_A_addr`  out  `ADDR_W`  read or write address
- `port_A_we`  out  1  write enable
- `port_A_data_in`  out  32  write data
- `port_A_data_out`  in  32  read data, valid one cycle after the address is presented

## Operation
- Stream format: each 32-bit word holds two 16-bit entries. Entry 0 is `[15:0]` and is processed first; entry 1 is `[31:16]`. Within an entry, the low byte is `count` and the high byte is `symbol`.
- `count` ranges 0..255. A count of 0 is a padding entry and produces no output.
- Output packing is little-endian: the first byte goes to `[7:0]`. A full word is written at `out_addr + 4k`.
- States:
  - IDLE: on `start`, latch the addresses and `rle_size`; clear `out_size`, the accumulator, the consumed count and `done`. Go to FETCH if the word-rounded size is greater than 0; otherwise go to FLUSH.
  - FETCH: present the read address with `we=0`. Go to WAIT.
  - WAIT: register `port_A_data_out`, advance the read address by 4, add 4 to the consumed count, load entry 0. Go to DECODE.
  - DECODE: handles one step per cycle.
    - If the remaining count is 0: advance to entry 1, or go to FETCH or FINISH when both entries are exhausted.
    - Otherwise append the symbol to the accumulator, decrement the remaining count, and increment `out_size`.
    - When the accumulator reaches 4 bytes, go to WRITE.
  - WRITE: drive `we=1` with the write address and the accumulator data, advance the write address by 4, clear the accumulator. Return to DECODE.
  - FINISH: entered when the consumed count equals the rounded `rle_size` and no entry remains. Go to FLUSH.
  - FLUSH: if the accumulator holds 1–3 bytes, write it zero-padded in the upper bytes; `out_size` is not padded. Go to IDLE and set `done`.
- Reads and writes are never issued in the same cycle; WRITE and FETCH are mutually exclusive states.
- `start` outside IDLE is ignored.
- Reset at any time, including mid-job, clears everything. Reset values:
  - state IDLE
  - `done=0`, `out_size=0`
  - `port_A_we=0`, `port_A_addr=0`, `port_A_data_in=0`
- `out_size` and the address registers wrap modulo 2^32 and 2^`ADDR_W` respectively, with no error flag.

## Timing
- `start` to the first read address: 1 cycle.
- Per input word: 2 cycles (FETCH, WAIT).
- Per nonzero output byte: 1 cycle. Per zero-count entry: 1 cycle.
- Per full output word: 1 extra WRITE cycle.
- Completion: FINISH, then FLUSH, then `done` high in the following cycle.
- `port_A_we` is high for exactly one cycle per word written.

## Configuration
- `RLE_DEC_WORD_FILL_EN` defined:
  - In DECODE, when the accumulator is empty and the remaining count is ≥ 4, load `{symbol,symbol,symbol,symbol}` in one cycle.
  - Subtract 4 from the remaining count and add 4 to `out_size`, then go to WRITE.
- Undefined: strictly one byte per cycle. Memory contents and `out_size` are identical in both builds; only cycle counts differ.

## Structure
- Shared package `rle_pkg`:
  - state enum
  - `WORD_BYTES=4`
  - entry field positions (`CNT_LSB=0`, `SYM_LSB=8`, `ENTRY_W=16`)
  - the format shared with the compressor
- One sub-module, `rle_byte_packer`: a 4-byte little-endian accumulator with inputs `push`, `push4`, `clear`, and outputs `full`, `empty`, `word`.

## Test plan
- Stream `{0x41 cnt 5, 0x42 cnt 3}` (word `0x4203_4105`), `rle_size=4` → writes `0x41414141`, then `0x42424241`; `out_size=8`, `done=1`.
- Entry `{0x7A cnt 2}` plus padding entry cnt 0, `rle_size=4` → one flush write `0x00007A7A`; `out_size=2`.
- `rle_size=0` → no `port_A_we` pulses; `done=1` within 3 cycles; `out_size=0`.
- Entry with count 255 for symbol 0xFF → 63 full words `0xFFFFFFFF` plus flush `0x00FFFFFF`; `out_size=255`.
  - With `RLE_DEC_WORD_FILL_EN`, the same memory result in fewer cycles.
- Assert `nreset` during DECODE of a long run → `we`, `done`, and `out_size` are 0 immediately. A new `start` then decodes correctly from scratch.
- Round trip: run the compressor output for random 64-byte messages into `rle_decode` → destination equals the original; `out_size=64`.
